// File: rtl/lif_spike_rate_meter.sv
// ---------------------------------------------------------------------------
// lif_spike_rate_meter
//
// Purpose:
//   Sits downstream of the LIF neuron's spike bus and turns raw spike pulses
//   into a firing-rate readout. Rising edges of "any spike bit set" are
//   counted over a programmable window of clock cycles. Each finished
//   window's count goes into a single-entry valid/ready output register,
//   along with a saturation flag. A sticky overrun flag records that an
//   unconsumed result was overwritten.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   i_spike_in     spike bus; a spike is present when any bit is 1
//   i_en           run enable; low aborts a window or holds the block idle
//   i_window_len   window length in cycles, sampled only at window start
//   i_rate_ready   consumer accepts the published rate
//   i_clear_flags  clears the sticky overrun flag
//   o_rate         spike count of the last completed window
//   o_rate_sat     that count saturated
//   o_rate_valid   o_rate/o_rate_sat hold an unconsumed result
//   o_overrun      sticky: an unconsumed result was overwritten
//   o_busy         high while a window is being counted
// ---------------------------------------------------------------------------
module lif_spike_rate_meter #(
    parameter int WIN_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       i_spike_in,
    input  logic             i_en,
    input  logic [WIN_W-1:0] i_window_len,
    input  logic             i_rate_ready,
    input  logic             i_clear_flags,
    output logic [CNT_W-1:0] o_rate,
    output logic             o_rate_sat,
    output logic             o_rate_valid,
    output logic             o_overrun,
    output logic             o_busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [WIN_W-1:0] r_timer;
    logic [WIN_W-1:0] w_timerNext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntLoad;
    logic             r_sat;
    logic             w_satLoad;
    logic             r_prevAny;

    logic             w_any;
    logic             w_event;
    logic             w_cntMax;
    logic [CNT_W-1:0] w_cntNext;
    logic             w_satNext;
    logic             w_lenNonZero;
    logic             w_publish;
    logic             w_overrunSet;

    // Onset detection: a level held high only counts on its first cycle,
    // even across window boundaries and idle gaps, because r_prevAny is
    // tracked in every state.
    assign w_any        = |i_spike_in;
    assign w_event      = w_any & ~r_prevAny;
    assign w_cntMax     = (r_cnt == {CNT_W{1'b1}});
    assign w_cntNext    = w_cntMax ? r_cnt : (r_cnt + CNT_W'(w_event));
    assign w_satNext    = r_sat | (w_cntMax & w_event);
    assign w_lenNonZero = (i_window_len != '0);

    assign o_busy = (r_state == COUNT);

    // Next-state and window-counter logic. The last sample cycle publishes
    // and reloads in the same edge, so back-to-back windows have no gap.
    always_comb begin
        w_nextState = r_state;
        w_timerNext = r_timer;
        w_cntLoad   = r_cnt;
        w_satLoad   = r_sat;
        w_publish   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_en && w_lenNonZero) begin
                    w_nextState = COUNT;
                    w_timerNext = i_window_len - WIN_W'(1);
                    w_cntLoad   = '0;
                    w_satLoad   = 1'b0;
                end
            end
            COUNT: begin
                if (!i_en) begin
                    // Abort: the partial count is simply abandoned.
                    w_nextState = IDLE;
                end else if (r_timer != '0) begin
                    w_timerNext = r_timer - WIN_W'(1);
                    w_cntLoad   = w_cntNext;
                    w_satLoad   = w_satNext;
                end else begin
                    w_publish = 1'b1;
                    if (w_lenNonZero) begin
                        w_timerNext = i_window_len - WIN_W'(1);
                        w_cntLoad   = '0;
                        w_satLoad   = 1'b0;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // State, window timer, counter and onset-history registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_cnt     <= '0;
            r_sat     <= 1'b0;
            r_prevAny <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_timer   <= w_timerNext;
            r_cnt     <= w_cntLoad;
            r_sat     <= w_satLoad;
            r_prevAny <= w_any;
        end
    end

    // Overwriting a result that has not been taken raises overrun; a
    // publish that coincides with a transfer is a clean hand-over.
    assign w_overrunSet = w_publish & o_rate_valid & ~i_rate_ready;

    // Single-entry output register with valid/ready handshake and the
    // sticky overrun flag (a new overrun beats a clear on the same edge).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rate       <= '0;
            o_rate_sat   <= 1'b0;
            o_rate_valid <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            if (w_publish) begin
                o_rate       <= w_cntNext;
                o_rate_sat   <= w_satNext;
                o_rate_valid <= 1'b1;
            end else if (o_rate_valid && i_rate_ready) begin
                o_rate_valid <= 1'b0;
            end
            o_overrun <= w_overrunSet | (o_overrun & ~i_clear_flags);
        end
    end

endmodule

// File: tb/tb_lif_spike_rate_meter.sv
// ---------------------------------------------------------------------------
// tb_lif_spike_rate_meter
//
// Purpose:
//   Self-checking bench for lif_spike_rate_meter. A window-level reference
//   model (unbounded integer onset count, cycles remaining in the window)
//   predicts the outputs after every clock edge. Directed sequences cover
//   the key scenarios with hard-coded expectations. A randomized phase then
//   exercises the handshake, aborts and mid-window length changes.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_lif_spike_rate_meter;

    localparam int WIN_W   = 16;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = 255;

    logic             clk;
    logic             rst;
    logic [7:0]       spikeIn;
    logic             en;
    logic [WIN_W-1:0] windowLen;
    logic             rateReady;
    logic             clearFlags;
    logic [CNT_W-1:0] rate;
    logic             rateSat;
    logic             rateValid;
    logic             overrun;
    logic             busy;

    int totalChecks = 0;
    int badChecks   = 0;

    // Reference model state, kept in terms of whole windows.
    bit         mActive;
    int         mRemain;
    int         mCount;
    bit         mPrevAny;
    logic [7:0] mRate;
    bit         mRateSat;
    bit         mValid;
    bit         mOverrun;

    lif_spike_rate_meter #(.WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_spike_in   (spikeIn),
        .i_en         (en),
        .i_window_len (windowLen),
        .i_rate_ready (rateReady),
        .i_clear_flags(clearFlags),
        .o_rate       (rate),
        .o_rate_sat   (rateSat),
        .o_rate_valid (rateValid),
        .o_overrun    (overrun),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mActive  = 0;
        mRemain  = 0;
        mCount   = 0;
        mPrevAny = 0;
        mRate    = '0;
        mRateSat = 0;
        mValid   = 0;
        mOverrun = 0;
    endtask

    // Advance the model by one clock edge using the inputs that are
    // present at that edge.
    task automatic modelStep();
        bit anyNow;
        bit onset;
        bit pub;
        bit setOvr;
        anyNow = (spikeIn != 8'h00);
        onset  = anyNow && !mPrevAny;
        pub    = 0;
        if (!mActive) begin
            if (en && windowLen != 0) begin
                mActive = 1;
                mRemain = int'(windowLen);
                mCount  = 0;
            end
        end else if (!en) begin
            mActive = 0;
        end else begin
            if (onset) mCount++;
            mRemain--;
            if (mRemain == 0) begin
                pub = 1;
                if (windowLen != 0) begin
                    mRemain = int'(windowLen);
                end else begin
                    mActive = 0;
                end
            end
        end
        setOvr = pub && mValid && !rateReady;
        if (pub) begin
            mRate    = 8'((mCount > CNT_MAX) ? CNT_MAX : mCount);
            mRateSat = (mCount > CNT_MAX);
            mValid   = 1;
            mCount   = 0;
        end else if (mValid && rateReady) begin
            mValid = 0;
        end
        mOverrun = setOvr || (mOverrun && !clearFlags);
        mPrevAny = anyNow;
    endtask

    task automatic checkAgainstModel();
        checkOutput("rate",       32'(rate),      32'(mRate));
        checkOutput("rate_sat",   32'(rateSat),   32'(mRateSat));
        checkOutput("rate_valid", 32'(rateValid), 32'(mValid));
        checkOutput("overrun",    32'(overrun),   32'(mOverrun));
        checkOutput("busy",       32'(busy),      32'(mActive));
    endtask

    // Drive one cycle of inputs away from the active edge, let the edge
    // happen, advance the model, then compare shortly after the edge.
    task automatic applyStimulus(input logic [7:0] sp, input logic e,
                                 input logic [WIN_W-1:0] len,
                                 input logic rdy, input logic clr);
        @(negedge clk);
        spikeIn    = sp;
        en         = e;
        windowLen  = len;
        rateReady  = rdy;
        clearFlags = clr;
        @(posedge clk);
        modelStep();
        #1;
        checkAgainstModel();
    endtask

    task automatic doReset();
        @(negedge clk);
        rst        = 1'b1;
        spikeIn    = '0;
        en         = 1'b0;
        windowLen  = '0;
        rateReady  = 1'b0;
        clearFlags = 1'b0;
        modelReset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        spikeIn    = '0;
        en         = 1'b0;
        windowLen  = '0;
        rateReady  = 1'b0;
        clearFlags = 1'b0;
        modelReset();
        #12;
        checkOutput("reset_rate",  32'(rate),      32'd0);
        checkOutput("reset_valid", 32'(rateValid), 32'd0);
        checkOutput("reset_busy",  32'(busy),      32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Window of 4, single-cycle spikes on samples 2 and 4.
        applyStimulus(8'h00, 1, 16'd4, 1, 0);
        applyStimulus(8'h00, 1, 16'd4, 1, 0);
        applyStimulus(8'h01, 1, 16'd4, 1, 0);
        applyStimulus(8'h00, 1, 16'd4, 1, 0);
        applyStimulus(8'h01, 1, 16'd4, 1, 0);
        checkOutput("w4_rate",  32'(rate),      32'd2);
        checkOutput("w4_valid", 32'(rateValid), 32'd1);
        checkOutput("w4_sat",   32'(rateSat),   32'd0);
        applyStimulus(8'h00, 1, 16'd4, 1, 0);
        checkOutput("w4_valid_drop", 32'(rateValid), 32'd0);
        checkOutput("w4_no_gap",     32'(busy),      32'd1);
        applyStimulus(8'h00, 0, 16'd4, 1, 0);

        // Held level spanning two windows, then a toggling bus.
        doReset();
        applyStimulus(8'h00, 1, 16'd4, 1, 0);
        for (int i = 0; i < 10; i++) applyStimulus(8'h80, 1, 16'd4, 1, 0);
        applyStimulus(8'h00, 0, 16'd4, 1, 0);
        doReset();
        applyStimulus(8'h00, 1, 16'd6, 1, 0);
        for (int i = 1; i <= 6; i++)
            applyStimulus((i % 2 == 1) ? 8'h03 : 8'h00, 1, 16'd6, 1, 0);
        checkOutput("toggle_rate", 32'(rate), 32'd3);
        applyStimulus(8'h00, 0, 16'd6, 1, 0);

        // Saturation: 300 onsets in a 600-cycle window.
        doReset();
        applyStimulus(8'h00, 1, 16'd600, 1, 0);
        for (int i = 1; i <= 600; i++)
            applyStimulus((i % 2 == 1) ? 8'h01 : 8'h00, 1, 16'd600, 1, 0);
        checkOutput("sat_rate", 32'(rate),    32'd255);
        checkOutput("sat_flag", 32'(rateSat), 32'd1);
        applyStimulus(8'h00, 0, 16'd600, 1, 0);

        // Overrun with two unconsumed windows of 3, then clear and drain.
        doReset();
        applyStimulus(8'h00, 1, 16'd3, 0, 0);
        applyStimulus(8'h01, 1, 16'd3, 0, 0);
        applyStimulus(8'h00, 1, 16'd3, 0, 0);
        applyStimulus(8'h00, 1, 16'd3, 0, 0);
        checkOutput("ovr_first_rate", 32'(rate), 32'd1);
        applyStimulus(8'h01, 1, 16'd3, 0, 0);
        applyStimulus(8'h00, 1, 16'd3, 0, 0);
        applyStimulus(8'h01, 1, 16'd3, 0, 0);
        checkOutput("ovr_rate",    32'(rate),      32'd2);
        checkOutput("ovr_valid",   32'(rateValid), 32'd1);
        checkOutput("ovr_flag",    32'(overrun),   32'd1);
        applyStimulus(8'h00, 0, 16'd3, 0, 1);
        checkOutput("ovr_cleared", 32'(overrun),   32'd0);
        checkOutput("ovr_held",    32'(rateValid), 32'd1);
        applyStimulus(8'h00, 0, 16'd3, 1, 0);
        checkOutput("ovr_drained", 32'(rateValid), 32'd0);

        // Abort in sample cycle 2, then a zero length must not start.
        applyStimulus(8'h00, 1, 16'd5, 1, 0);
        applyStimulus(8'h01, 1, 16'd5, 1, 0);
        applyStimulus(8'h00, 0, 16'd5, 1, 0);
        checkOutput("abort_busy",  32'(busy),      32'd0);
        checkOutput("abort_valid", 32'(rateValid), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(8'h00, 1, 16'd0, 1, 0);
        checkOutput("len0_idle", 32'(busy), 32'd0);

        // Asynchronous reset mid-window with a pending result.
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(8'h01, 1, 16'd1, 0, 0);
        checkOutput("pre_rst_valid", 32'(rateValid), 32'd1);
        checkOutput("pre_rst_busy",  32'(busy),      32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("arst_valid",   32'(rateValid), 32'd0);
        checkOutput("arst_busy",    32'(busy),      32'd0);
        checkOutput("arst_overrun", 32'(overrun),   32'd0);
        checkOutput("arst_rate",    32'(rate),      32'd0);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(8'h00, 0, 16'd1, 0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            logic [7:0]       sp;
            logic [WIN_W-1:0] len;
            sp  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            len = ($urandom_range(0, 15) == 0) ? WIN_W'($urandom_range(0, 40))
                                              : WIN_W'($urandom_range(0, 6));
            applyStimulus(sp, ($urandom_range(0, 24) != 0), len,
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 9) == 0));
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
